serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: combinational full-adder cell plus a clocked LSB-first result accumulator.
- Each cycle the caller presents one bit of each operand and a carry-in, and receives the sum bit and carry-out in the same cycle.
- The block collects WIDTH sum bits into a parallel word and flags completion.
- It sits between a shift-register operand source and a consumer needing the parallel sum. The caller may close the carry loop externally (c_out fed back to c_in).

Parameters:
- WIDTH, 8, operand/result width in bits (number of serial cycles per word; >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  current operand-A bit, LSB first.
- b  input  1  current operand-B bit, LSB first.
- c_in  input  1  carry into current bit position.
- clear  input  1  synchronous restart of accumulation; tie low if unused.
- sum  output  1  combinational sum bit, a^b^c_in.
- c_out  output  1  combinational carry, majority(a,b,c_in).
- result  output  WIDTH  accumulated sum word; bit i = sum captured on i-th accumulation edge.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits accumulated so far.
- done  output  1  high when bit_cnt == WIDTH.
- overflow  output  1  c_out captured on the WIDTH-th accumulation edge.

Behaviour:
- sum and c_out are purely combinational. They have zero latency and are valid whenever a, b and c_in are stable, independent of clk, rst_n and done.
- Reset (rst_n low, asynchronous): result=0, bit_cnt=0, done=0, overflow=0. sum and c_out are unaffected.
- Accumulating (bit_cnt < WIDTH), each rising edge:
  - result <= {sum, result[WIDTH-1:1]}
  - bit_cnt <= bit_cnt+1
  - On the edge where bit_cnt goes WIDTH-1 -> WIDTH, overflow <= c_out.
- Done (bit_cnt == WIDTH): result, bit_cnt and overflow hold. done=1. Further a/b/c_in activity is ignored by the registers.
- After WIDTH edges, result == (A + B + initial c_in) mod 2^WIDTH, and overflow is that word's carry-out.
- clear=1 at a rising edge: result=0, bit_cnt=0, overflow=0. Accumulation restarts next edge. clear has priority over accumulation, including mid-word and while done.
- Reset asserted mid-word: registers clear immediately. Accumulation resumes on the first rising edge after rst_n deasserts.
- done is a combinational decode of bit_cnt, and bit_cnt never exceeds WIDTH.
- The block does not store the carry. Carry propagation between bits is the caller's responsibility (register c_out into c_in at the same edge).

Decomposition:
- Shared package serial_adder_pkg:
  - DEFAULT_WIDTH = 8.
  - Function for counter width, clog2(WIDTH+1).
- One sub-module is natural: full_adder_bit. It is the combinational a/b/c_in -> sum/c_out cell, instanced once.
- The accumulator and counter live in the top.

Test Plan:
- 55 + 17, c_in loop from 0, 8 edges -> result=0x48 (72), overflow=0, done=1 after 8th edge, sum/c_out correct every cycle.
- 255 + 1 -> result=0x00, overflow=1; 170 + 85 -> result=0xFF, overflow=0; 0 + 0 -> result=0x00, overflow=0.
- Exhaustive 3-input truth table on a/b/c_in (all 8 combos, no clock) -> sum and c_out match the full-adder table.
- Keep toggling inputs for 4 extra edges after done -> result, bit_cnt and overflow unchanged.
- clear pulse after 3 bits, then full 100 + 27 -> result=127, bit_cnt restarts at 0, overflow=0.
- rst_n low between edges mid-word (bit_cnt=5) -> all registers 0 immediately without a clock edge. After release, 200 + 100 -> result=44, overflow=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared parameters and helpers for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must reach WIDTH itself, hence WIDTH+1 states.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit full adder cell.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: full-adder cell plus LSB-first result accumulator.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c_in,
    input  logic             clear,
    output logic             sum,
    output logic             c_out,
    output logic [WIDTH-1:0] result,
    output logic [CW-1:0]    bit_cnt,
    output logic             done,
    output logic             overflow
);

    full_adder_bit u_fa (
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    assign done = (bit_cnt == CW'(WIDTH));

    // Sum bits enter at the MSB so the first (LSB) bit ends up at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            result   <= '0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else if (!done) begin
            result  <= {sum, result[WIDTH-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH - 1))
                overflow <= c_out;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a word-level arithmetic model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a, b, c_in, clear;
    logic         sum, c_out;
    logic [W-1:0] result;
    logic [3:0]   bit_cnt;
    logic         done, overflow;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: number of bits accumulated and the full-precision word total.
    int mdl_k     = 0;
    int mdl_total = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .clear    (clear),
        .sum      (sum),
        .c_out    (c_out),
        .result   (result),
        .bit_cnt  (bit_cnt),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // After k edges the low k bits of the total sit in the top k bits of result.
    function automatic int exp_res(input int k, input int tot);
        if (k == 0) return 0;
        return ((tot % (1 << k)) << (W - k)) & ((1 << W) - 1);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("result", int'(result), exp_res(mdl_k, mdl_total));
            chk("bit_cnt", int'(bit_cnt), mdl_k);
            chk("done", int'(done), int'(mdl_k == W));
            chk("overflow", int'(overflow), (mdl_k == W) ? (mdl_total >> W) & 1 : 0);
        end
    end

    // Drive n bits of A+B LSB-first with the carry loop closed by the bench.
    task automatic run_bits(input int A, input int B, input int cin0, input int n);
        int carry;
        int s;
        carry     = cin0;
        mdl_total = A + B + cin0;
        for (int i = 0; i < n; i++) begin
            a    = A[i];
            b    = B[i];
            c_in = carry[0];
            #1;
            s = int'(A[i]) + int'(B[i]) + carry;
            chk("sum", int'(sum), s & 1);
            chk("c_out", int'(c_out), s >> 1);
            @(posedge clk);
            #1;
            if (mdl_k < W) mdl_k++;
            carry = s >> 1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        a     = 1'($urandom);
        b     = 1'($urandom);
        c_in  = 1'($urandom);
        @(posedge clk);
        #1;
        mdl_k = 0;
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; c_in = 1'b0; clear = 1'b1;
        #2;
        chk("rst_result", int'(result), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);

        // Full-adder truth table, combinational only.
        for (int v = 0; v < 8; v++) begin
            a = v[2]; b = v[1]; c_in = v[0];
            #1;
            chk("tt_sum", int'(sum), (int'(v[2]) + int'(v[1]) + int'(v[0])) & 1);
            chk("tt_c_out", int'(c_out), int'((int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2));
        end

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        chk_en = 1'b1;

        // 55 + 17 = 72
        run_bits(55, 17, 0, W);
        chk("w1_result", int'(result), 8'h48);
        chk("w1_overflow", int'(overflow), 0);
        chk("w1_done", int'(done), 1);

        // Inputs toggling after done must be ignored.
        for (int i = 0; i < 4; i++) begin
            a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("hold_result", int'(result), 8'h48);
        chk("hold_bit_cnt", int'(bit_cnt), W);
        chk("hold_overflow", int'(overflow), 0);

        do_clear();
        run_bits(255, 1, 0, W);
        chk("w2_result", int'(result), 0);
        chk("w2_overflow", int'(overflow), 1);

        do_clear();
        run_bits(170, 85, 0, W);
        chk("w3_result", int'(result), 8'hFF);
        chk("w3_overflow", int'(overflow), 0);

        do_clear();
        run_bits(0, 0, 0, W);
        chk("w4_result", int'(result), 0);
        chk("w4_overflow", int'(overflow), 0);

        // Clear mid-word, then a full word.
        do_clear();
        run_bits(100, 27, 0, 3);
        chk("mid_bit_cnt", int'(bit_cnt), 3);
        do_clear();
        chk("clr_bit_cnt", int'(bit_cnt), 0);
        chk("clr_result", int'(result), 0);
        run_bits(100, 27, 0, W);
        chk("w5_result", int'(result), 127);
        chk("w5_overflow", int'(overflow), 0);

        // Asynchronous reset between edges mid-word.
        do_clear();
        run_bits(200, 100, 0, 5);
        chk("pre_rst_bit_cnt", int'(bit_cnt), 5);
        #2;
        rst_n = 1'b0;
        mdl_k = 0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_bit_cnt", int'(bit_cnt), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        run_bits(200, 100, 0, W);
        chk("w6_result", int'(result), 44);
        chk("w6_overflow", int'(overflow), 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
